// File: rtl/data_memory_responder.sv
// Word-addressed data memory slave with a fixed, parameterised wait-state count.
// The request is captured on acceptance; the access and a one-cycle Ack happen after LATENCY waits.
module data_memory_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        ReadEnable,
  input  logic        WriteEnable,
  input  logic [3:0]  ByteEnable,
  output logic [31:0] ReadData,
  output logic        Ack,
  output logic        Busy
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            write_q, write_d;
  logic            oor_q, oor_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [DEPTH];

  logic            req;
  logic            accept;
  logic            do_access;
  logic            mem_we;

  // Byte offset within the word plays no part in addressing.
  logic            unused_addr;
  assign unused_addr = ^Address[1:0];

  assign req = ReadEnable | WriteEnable;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          accept  = 1'b1;
          state_d = StWait;
          cnt_d   = 4'(LATENCY);
        end
      end
      StWait: begin
        if (!req) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        // A request still held here starts the next transaction straight away.
        if (req) begin
          accept  = 1'b1;
          state_d = StWait;
          cnt_d   = 4'(LATENCY);
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    write_d = write_q;
    oor_d   = oor_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    if (accept) begin
      write_d = WriteEnable;
      oor_d   = |(Address >> (AW + 2));
      idx_d   = Address[AW+1:2];
      wdata_d = WriteData;
      be_d    = ByteEnable;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (do_access && !write_q) begin
      rdata_d = oor_q ? 32'h0000_0000 : mem_q[idx_q];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0000_0000;
      be_q    <= 4'h0;
      rdata_q <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      oor_q   <= oor_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is deliberately outside the reset domain; reset only blocks a pending write.
  assign mem_we = do_access & write_q & ~oor_q & ~RST;

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign ReadData = rdata_q;
  assign Ack      = (state_q == StAck);
  assign Busy     = (state_q == StWait);

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: directed scenarios plus randomized transactions against a word-array model.
module tb_data_memory_responder;

  localparam int Lat = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] Address, WriteData;
  logic        ReadEnable, WriteEnable;
  logic [3:0]  ByteEnable;
  logic [31:0] ReadData;
  logic        Ack, Busy;

  logic [31:0] a0_addr, a0_wdata, a0_rdata;
  logic        a0_re, a0_we, a0_ack, a0_busy;
  logic [3:0]  a0_be;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem_m [256];
  logic [31:0] rd_m;

  always #5 CLK = ~CLK;

  data_memory_responder #(.DEPTH(256), .LATENCY(Lat)) u_dut (
    .CLK        (CLK),
    .RST        (RST),
    .Address    (Address),
    .WriteData  (WriteData),
    .ReadEnable (ReadEnable),
    .WriteEnable(WriteEnable),
    .ByteEnable (ByteEnable),
    .ReadData   (ReadData),
    .Ack        (Ack),
    .Busy       (Busy)
  );

  data_memory_responder #(.DEPTH(16), .LATENCY(0)) u_dut0 (
    .CLK        (CLK),
    .RST        (RST),
    .Address    (a0_addr),
    .WriteData  (a0_wdata),
    .ReadEnable (a0_re),
    .WriteEnable(a0_we),
    .ByteEnable (a0_be),
    .ReadData   (a0_rdata),
    .Ack        (a0_ack),
    .Busy       (a0_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return (a >> 10) == 32'd0;
  endfunction

  // Issue one request on u_dut, scramble non-enable inputs while waiting, check timing and data.
  task automatic txn(input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be, input string tag);
    int n;
    ReadEnable  = rd;
    WriteEnable = wr;
    Address     = a;
    WriteData   = d;
    ByteEnable  = be;
    @(posedge CLK); #1;
    n = 0;
    while (Ack !== 1'b1 && n < 40) begin
      chk({tag, " busy"}, {31'd0, Busy}, 32'd1);
      Address    = $urandom;
      WriteData  = $urandom;
      ByteEnable = 4'($urandom);
      @(posedge CLK); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(Lat + 1));
    if (wr) begin
      if (in_range(a)) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem_m[a[9:2]][8*i +: 8] = d[8*i +: 8];
        end
      end
    end else begin
      rd_m = in_range(a) ? mem_m[a[9:2]] : 32'h0;
    end
    chk({tag, " rdata"}, ReadData, rd_m);
    chk({tag, " busy at ack"}, {31'd0, Busy}, 32'd0);
    ReadEnable  = 1'b0;
    WriteEnable = 1'b0;
    @(posedge CLK); #1;
    chk({tag, " ack width"}, {31'd0, Ack}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    logic        r, w;
    RST = 1'b1;
    {ReadEnable, WriteEnable, Address, WriteData, ByteEnable} = '0;
    {a0_re, a0_we, a0_addr, a0_wdata, a0_be} = '0;
    rd_m = 32'h0;
    #1;
    chk("reset ack", {31'd0, Ack}, 32'd0);
    chk("reset busy", {31'd0, Busy}, 32'd0);
    chk("reset rdata", ReadData, 32'h0);
    chk("reset ack0", {31'd0, a0_ack}, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Preload every word so later reads have defined contents.
    for (int i = 0; i < 256; i++) txn(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, "preload");

    txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, "wr 0x10");
    txn(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "rd 0x10");
    chk("deadbeef", ReadData, 32'hDEAD_BEEF);

    txn(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, "wr 0x20");
    txn(1'b0, 1'b1, 32'h22, 32'hAABB_CCDD, 4'b0101, "partial wr");
    txn(1'b1, 1'b0, 32'h21, 32'h0, 4'h0, "partial rd");
    chk("partial value", ReadData, 32'h11BB_33DD);
    txn(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, "be0 wr");
    txn(1'b1, 1'b1, 32'h20, 32'h0BAD_F00D, 4'b1000, "both wr");
    txn(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, "be0 rd");

    txn(1'b1, 1'b0, 32'h400, 32'h0, 4'hF, "oor rd");
    chk("oor zero", ReadData, 32'h0);
    txn(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, "word0 before");
    txn(1'b0, 1'b1, 32'h400, 32'h1234_5678, 4'hF, "oor wr");
    txn(1'b1, 1'b0, 32'h0, 32'h0, 4'hF, "word0 after");

    // Abort: drop the read one cycle after acceptance.
    ReadEnable = 1'b1;
    Address    = 32'h20;
    @(posedge CLK); #1;
    chk("abort busy", {31'd0, Busy}, 32'd1);
    ReadEnable = 1'b0;
    @(posedge CLK); #1;
    chk("abort busy low", {31'd0, Busy}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("abort no ack", {31'd0, Ack}, 32'd0);
      @(posedge CLK); #1;
    end
    chk("abort rdata", ReadData, rd_m);

    // Reset during the wait of a write.
    txn(1'b0, 1'b1, 32'h04, 32'h0102_0304, 4'hF, "pre wr 0x04");
    txn(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, "pre rd 0x04");
    WriteEnable = 1'b1;
    Address     = 32'h04;
    WriteData   = 32'hCAFE_F00D;
    ByteEnable  = 4'hF;
    @(posedge CLK); #1;
    chk("rst pre busy", {31'd0, Busy}, 32'd1);
    RST = 1'b1;
    #1;
    chk("rst ack", {31'd0, Ack}, 32'd0);
    chk("rst busy", {31'd0, Busy}, 32'd0);
    chk("rst rdata", ReadData, 32'h0);
    rd_m = 32'h0;
    @(posedge CLK); #1;
    WriteEnable = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;
    txn(1'b1, 1'b0, 32'h04, 32'h0, 4'hF, "post rst rd");
    chk("post rst value", ReadData, 32'h0102_0304);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : {22'd0, 10'($urandom)};
      d = $urandom;
      r = 1'($urandom);
      w = ~r | 1'($urandom);
      txn(r, w, a, d, 4'($urandom), "random");
    end

    // LATENCY=0 instance with a continuously held write.
    a0_we    = 1'b1;
    a0_addr  = 32'h8;
    a0_wdata = 32'h5A5A_1234;
    a0_be    = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(posedge CLK); #1;
      chk("b2b ack", {31'd0, a0_ack}, 32'(k % 2));
      chk("b2b busy", {31'd0, a0_busy}, 32'((k + 1) % 2));
    end
    a0_we = 1'b0;
    a0_re = 1'b1;
    @(posedge CLK); #1;
    chk("lat0 rd wait", {31'd0, a0_ack}, 32'd0);
    @(posedge CLK); #1;
    chk("lat0 rd ack", {31'd0, a0_ack}, 32'd1);
    chk("lat0 rdata", a0_rdata, 32'h5A5A_1234);
    a0_re = 1'b0;
    @(posedge CLK); #1;
    chk("lat0 ack drop", {31'd0, a0_ack}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
